// File: rtl/slice_serial_add_sub.sv
// ============================================================================
// Module      : slice_serial_add_sub
// Description : Multi-cycle add/subtract unit. Each clock it adds one
//               SLICE-bit ripple slice of two WIDTH-bit operands. The carry
//               is kept in a register between slices. Valid/ready handshakes
//               are used on both the input and the output side.
//
// Ports       : clk        - sole clock, rising edge
//               reset_n    - asynchronous active-low reset
//               in_valid   - operands valid          in_ready  - can accept
//               a, b       - operands (WIDTH)        sub       - 0 add, 1 sub
//               cin        - carry-in / borrow-in
//               out_valid  - result valid            out_ready - result taken
//               sum        - result (WIDTH)          cout      - carry out
//               ovf        - signed overflow         zero      - sum == 0
//
// Parameters  : WIDTH (16) operand width, SLICE (4) bits per cycle;
//               WIDTH must be a multiple of SLICE.
// Option      : define SLICE_SERIAL_ADD_SUB_SAT_EN to saturate sum on
//               signed overflow (cout/ovf still report raw values).
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slice_serial_add_sub #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int c_nslice = WIDTH / SLICE;
  localparam int c_cw     = (c_nslice > 1) ? $clog2(c_nslice) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(c_nslice - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  generate
    if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_param
      $error("slice_serial_add_sub: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  logic [1:0]                        r_state;
  logic [c_nslice-1:0][SLICE-1:0]    r_opa;
  logic [c_nslice-1:0][SLICE-1:0]    r_opb;
  logic [c_nslice-1:0][SLICE-1:0]    r_sum;
  logic [c_cw-1:0]                   r_cnt;
  logic                              r_carry;
  logic                              r_cout;
  logic                              r_ovf;
  logic                              r_zero;

  logic [SLICE-1:0]                  w_sa;
  logic [SLICE-1:0]                  w_sb;
  logic [SLICE:0]                    w_slice;
  logic                              w_msb_cin;
  logic                              w_ovf;
  logic                              w_last;
  logic [c_nslice-1:0][SLICE-1:0]    w_next_sum;
  logic [WIDTH-1:0]                  w_final;
  logic                              w_zero;

  // Current slice of both operands, selected by the slice counter.
  assign w_sa    = r_opa[r_cnt];
  assign w_sb    = r_opb[r_cnt];
  assign w_slice = {1'b0, w_sa} + {1'b0, w_sb} + {{SLICE{1'b0}}, r_carry};
  assign w_last  = (r_cnt == c_last);

  // Carry into the slice MSB recovered from the MSB sum bit:
  // s = a ^ b ^ c_in  =>  c_in = a ^ b ^ s. Only meaningful on the last slice.
  assign w_msb_cin = w_sa[SLICE-1] ^ w_sb[SLICE-1] ^ w_slice[SLICE-1];
  assign w_ovf     = w_msb_cin ^ w_slice[SLICE];

  // Full result with the slice being computed this cycle merged in, so the
  // zero flag sees every bit of the finished sum.
  always_comb begin
    w_next_sum        = r_sum;
    w_next_sum[r_cnt] = w_slice[SLICE-1:0];
  end

`ifdef SLICE_SERIAL_ADD_SUB_SAT_EN
  // Overflow direction follows the sign of opA: a positive opA can only
  // overflow upwards (0x7F..F), a negative one downwards (0x80..0).
  logic w_sign_a;
  assign w_sign_a = r_opa[c_nslice-1][SLICE-1];
  assign w_final  = w_ovf ? {w_sign_a, {(WIDTH-1){~w_sign_a}}} : WIDTH'(w_next_sum);
`else
  assign w_final  = WIDTH'(w_next_sum);
`endif

  assign w_zero = (w_final == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_st_idle;
      r_opa   <= '0;
      r_opb   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (in_valid) begin
            // Subtraction is a + ~b + !borrow, so fold sub into opB and carry.
            r_opa   <= a;
            r_opb   <= sub ? ~b : b;
            r_carry <= cin ^ sub;
            r_cnt   <= '0;
            r_state <= c_st_run;
          end
        end
        c_st_run: begin
          r_carry <= w_slice[SLICE];
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum   <= w_final;
            r_cout  <= w_slice[SLICE];
            r_ovf   <= w_ovf;
            r_zero  <= w_zero;
            r_state <= c_st_done;
          end else begin
            r_sum   <= w_next_sum;
          end
        end
        c_st_done: begin
          if (out_ready) begin
            r_state <= c_st_idle;
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == c_st_idle);
  assign out_valid = (r_state == c_st_done);
  assign sum       = WIDTH'(r_sum);
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

`default_nettype wire

// File: doc/slice_serial_add_sub.md
Name: slice_serial_add_sub

Overview:
- Parametrised multi-cycle successor to the 4-bit ripple-carry adder in the execution unit.
- Adds or subtracts two WIDTH-bit operands using one SLICE-bit ripple slice per clock.
- Holds the carry in a register between slices.
- Valid/ready on input and output, so it sits between operand fetch and writeback; flags feed condition logic.

Parameters:
- WIDTH, 16, operand/result width in bits.
- SLICE, 4, bits processed per cycle. WIDTH % SLICE != 0 is an elaboration error. NSLICE = WIDTH/SLICE; NSLICE = 1 is legal.

Ports:
- clk  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  augend/minuend.
- b  input  WIDTH  addend/subtrahend.
- sub  input  1  0 = add, 1 = subtract.
- cin  input  1  carry-in (add) / borrow-in (sub).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  sum == 0.

Behaviour:
- Reset (asynchronous assert, synchronous deassert on clk): state IDLE; in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, zero=0; slice counter=0; carry reg=0.
- State IDLE:
  - in_ready=1.
  - Accept on in_valid && in_ready at the clk edge.
  - Latch a into opA and (sub ? ~b : b) into opB; carry reg = cin ^ sub; counter=0; go to RUN.
- State RUN:
  - in_ready=0.
  - Each cycle, add slice k = counter: opA[k*SLICE +: SLICE] + opB[same] + carry.
  - Write the result into sum[k*SLICE +: SLICE] and the slice carry-out into the carry reg; counter++.
  - On the last slice (k = NSLICE-1):
    - cout = final carry.
    - ovf = carry into MSB ^ carry out of MSB.
    - zero = (full sum == 0), including the slice just written.
    - Go to DONE.
- State DONE:
  - out_valid=1; in_ready=0.
  - sum/cout/ovf/zero held stable until out_ready=1.
  - On out_valid && out_ready, go to IDLE with out_valid=0.
- Latency:
  - out_valid rises exactly NSLICE cycles after the accepting edge.
  - Minimum initiation interval is NSLICE+2 cycles: no accept in the same cycle as the output handshake.
- Arithmetic:
  - sub=0: sum = a + b + cin.
  - sub=1: sum = a - b - cin, computed as a + ~b + !cin.
  - All results are modulo 2^WIDTH.
- Input stability: a, b, sub and cin are sampled only at accept. Changes while in RUN or DONE are ignored.
- Intermediate values: during RUN, sum bits are partially updated and undefined to the consumer. Only out_valid qualifies sum.
- Output hold: after the output handshake, sum and flags keep their last values until the next operation's RUN overwrites them.
- Reset mid-operation: the operation is dropped. All state and outputs return to reset values immediately and asynchronously. No out_valid pulse is produced.
- Invariant: in_ready and out_valid are never both 1.

Optional Feature:
- Macro: SLICE_SERIAL_ADD_SUB_SAT_EN.
- Defined:
  - On the final slice, if ovf=1, sum is replaced by a signed saturated value.
  - The value is 0x7FF..F if the true result is positive, i.e. the operand-sign MSB of opA is 0. Otherwise it is 0x800..0.
  - zero is recomputed on the saturated value (always 0).
  - ovf and cout still report raw values.
  - Latency unchanged.
- Undefined: sum wraps modulo 2^WIDTH and no saturation logic exists.

Test Plan:
- WIDTH=16, SLICE=4: a=0x1234, b=0x4321, sub=0, cin=0 → out_valid 4 cycles after accept; sum=0x5555, cout=0, ovf=0, zero=0.
- a=0xFFFF, b=0x0001, sub=0 (carry ripples through all 4 slices) → sum=0x0000, cout=1, ovf=0, zero=1. Also a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1, cout=0 (with SAT_EN: sum=0x7FFF).
- Subtract a=0x0005, b=0x0007, sub=1, cin=0 → sum=0xFFFE, cout=0, ovf=0. Repeat with cin=1 → sum=0xFFFD.
- Backpressure: out_ready=0 for 5 cycles after out_valid → sum/flags stable, in_ready=0 and in_valid ignored. The out_ready pulse then drops out_valid, and in_ready=1 the next cycle.
- Change a/b during RUN → result reflects the values latched at accept. Assert reset_n=0 mid-RUN (counter=2) → outputs are 0 immediately; after release, the next op is computed correctly.
- Param sweep WIDTH=8/SLICE=8 and WIDTH=32/SLICE=2 → latency 1 and 16 cycles respectively. Random 1000-op scoreboard against a reference model matches sum/cout/ovf/zero.
